load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data memory port. Accepts one load/store request at a time from the core's memory stage over a valid/ready handshake.
- Drives the data memory's address, write-data, size, write-enable and unsigned inputs, and returns load data or store completion with a one-cycle response pulse.
- Aligned accesses complete in a single memory beat. Misaligned half/word accesses are split into little-endian byte beats, reassembled, then sign- or zero-extended.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = split misaligned accesses into byte beats; 0 = reject them with resp_err.
- ADDR_WIDTH, 32: request and memory address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid only with resp_valid
- mem_a  out  ADDR_WIDTH  memory address
- mem_wd  out  32  memory write data
- mem_size  out  2  memory access size
- mem_we  out  1  memory write enable
- mem_unsigned  out  1  memory extension select
- mem_rd  in  32  memory read data, valid during the beat cycle

Behaviour:
- Reset (async, immediate) forces:
  - state = IDLE
  - req_ready = 1
  - resp_valid = 0, resp_err = 0, resp_rdata = 0
  - mem_we = 0, mem_a = 0, mem_wd = 0, mem_size = 00, mem_unsigned = 0
  - beat counter = 0, assembly register = 0
- States:
  - IDLE -> BEAT on accept (req_valid && req_ready).
  - IDLE -> RESP on accept of an illegal request.
  - BEAT -> BEAT while beat index < last.
  - BEAT -> RESP after the last beat.
  - RESP -> IDLE unconditionally.
- req_ready = 1 only in IDLE. Request fields are captured at the accepting edge. Inputs are ignored outside IDLE.
- Illegal request: size 11, or misaligned with SPLIT_MISALIGNED = 0. No memory beat is issued, mem_we stays 0, and RESP asserts resp_err = 1 with resp_rdata = 0.
- Misaligned means: half with addr[0] = 1, or word with addr[1:0] != 00.
- Aligned access, one beat:
  - mem_a = addr; mem_size and mem_unsigned = captured values; mem_wd = wdata; mem_we = captured we.
  - Load data = mem_rd, sampled at the edge ending the beat.
- Misaligned access: N byte beats, N = 2 for half and 4 for word. For beat i:
  - mem_a = addr + i, wrapping mod 2^ADDR_WIDTH
  - mem_size = 00, mem_unsigned = 1
  - mem_wd = {24'b0, wdata[8i+7:8i]}
  - mem_we = captured we
  - loads store mem_rd[7:0] into assembly byte i at the end of the beat
- Split-load extension: bit 15 (half) or bit 31 (word) of the assembled value, per captured unsigned. Word extension is a no-op.
- mem_we is asserted only in BEAT. All mem_* outputs are registered and change only at edges. They return to 0 outside BEAT.
- Latency from accept edge to resp_valid high:
  - aligned: 2 cycles
  - misaligned half: 3 cycles
  - misaligned word: 5 cycles
  - illegal: 1 cycle
- resp_valid lasts exactly one cycle and has no backpressure. Next accept is possible the cycle after RESP.
- Stores respond with resp_rdata = 0 and resp_err = 0.
- Reset mid-operation:
  - all outputs return to reset values immediately
  - bytes already written by earlier beats remain in memory
  - no response is issued for the aborted request

Decomposition:
- Shared package lsu_pkg:
  - size encodings SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10
  - state encoding IDLE / BEAT / RESP
  - function returning beat count from size and addr[1:0]
- One natural sub-module: load_extend. Combinational; takes 32-bit raw data, size and unsigned; produces the extended 32-bit value. Used for split loads.

Test Plan:
- Aligned word store 0xDEADBEEF @0x0:
  - one beat with mem_we = 1, mem_a = 0, mem_size = 10; resp_valid 2 cycles after accept, err = 0.
  - Load word @0x0 then returns 0xDEADBEEF.
- Misaligned word store 0x11223344 @0x5:
  - four beats, mem_a 5, 6, 7, 8 with mem_wd low bytes 44, 33, 22, 11.
  - Word load @0x5 returns 0x11223344, resp 5 cycles after accept.
- Misaligned half load @0x7 with memory bytes 0x01 @7 and 0x80 @8:
  - signed -> 0xFFFF8001
  - unsigned -> 0x00008001
- Aligned byte @0x4 holding 0xA5:
  - signed -> 0xFFFFFFA5
  - unsigned -> 0x000000A5
- Illegal requests: size 11, and SPLIT_MISALIGNED = 0 with word @0x2:
  - no mem_we pulse; resp_err = 1, resp_rdata = 0, resp 1 cycle after accept.
- Reset and wrap-around:
  - rst asserted during beat 2 of misaligned word store @0xFFFFFFFF: mem_we drops immediately; req_ready = 1 after release; bytes at 0xFFFFFFFF and 0x0 written, 0x1 and 0x2 untouched.
  - Unreset rerun of the same request: beats at 0xFFFFFFFF, 0x0, 0x1, 0x2.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings and helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access size encodings on both the request and the memory side
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BEAT = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // Half on an odd byte, or word off a 4-byte boundary
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = ((size == SIZE_HALF) && lo[0]) ||
          ((size == SIZE_WORD) && (lo != 2'b00));
    return mis;
  endfunction

  // Number of memory beats an access needs; 0 for the illegal size
  function automatic logic [2:0] beat_count(input logic [1:0] size, input logic [1:0] lo);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = lo[0] ? 3'd2 : 3'd1;
      SIZE_WORD: n = (lo != 2'b00) ? 3'd4 : 3'd1;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Sign/zero extension of an assembled little-endian load value.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  // Replicate the top bit of the access width unless zero-extension is asked for
  always_comb begin
    o_data = i_raw;
    case (i_size)
      SIZE_BYTE: o_data = {{24{~i_unsigned & i_raw[7]}}, i_raw[7:0]};
      SIZE_HALF: o_data = {{16{~i_unsigned & i_raw[15]}}, i_raw[15:0]};
      default:   o_data = i_raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Data-memory initiator. Single outstanding request; misaligned
//               half/word accesses are optionally split into byte beats.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SPLIT_MISALIGNED = 1,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  output logic                  o_resp_valid,
  output logic [31:0]           o_resp_rdata,
  output logic                  o_resp_err,
  output logic [ADDR_WIDTH-1:0] o_mem_a,
  output logic [31:0]           o_mem_wd,
  output logic [1:0]            o_mem_size,
  output logic                  o_mem_we,
  output logic                  o_mem_unsigned,
  input  logic [31:0]           i_mem_rd
);

  // Captured request
  lsu_state_t            r_state;
  logic                  r_we;
  logic                  r_unsigned;
  logic                  r_split;
  logic [1:0]            r_size;
  logic [1:0]            r_beat;
  logic [2:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_asm;

  // Registered outputs
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [31:0]           r_resp_rdata;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [31:0]           r_mem_wd;
  logic [1:0]            r_mem_size;
  logic                  r_mem_we;
  logic                  r_mem_unsigned;

  logic                  w_accept;
  logic                  w_mis;
  logic                  w_illegal;
  logic                  w_last;
  logic [2:0]            w_nbeats;
  logic [2:0]            w_next_beat;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [7:0]            w_next_byte;
  logic [4:0]            w_shift;
  logic [31:0]           w_asm_next;
  logic [31:0]           w_ext;

  assign w_accept    = i_req_valid && r_req_ready;
  assign w_mis       = is_misaligned(i_req_size, i_req_addr[1:0]);
  assign w_illegal   = (i_req_size == SIZE_ILL) || (w_mis && (SPLIT_MISALIGNED == 0));
  assign w_nbeats    = beat_count(i_req_size, i_req_addr[1:0]);
  assign w_next_beat = {1'b0, r_beat} + 3'd1;
  assign w_last      = (w_next_beat == r_count);
  // Address of the following byte beat; wraps naturally at the top of memory
  assign w_next_addr = r_addr + {{(ADDR_WIDTH-3){1'b0}}, w_next_beat};
  // Merge this beat's byte into its little-endian lane of the assembly
  assign w_shift     = {r_beat, 3'b000};
  assign w_asm_next  = (r_asm & ~(32'h0000_00FF << w_shift)) |
                       ({24'h0, i_mem_rd[7:0]} << w_shift);

  // Store byte presented on the next split beat
  always_comb begin
    w_next_byte = r_wdata[7:0];
    case (w_next_beat[1:0])
      2'd1:    w_next_byte = r_wdata[15:8];
      2'd2:    w_next_byte = r_wdata[23:16];
      2'd3:    w_next_byte = r_wdata[31:24];
      default: w_next_byte = r_wdata[7:0];
    endcase
  end

  load_extend u_extend (
    .i_raw      (w_asm_next),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  // Request sequencer: accept, issue beats, emit the one-cycle response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_we           <= 1'b0;
      r_unsigned     <= 1'b0;
      r_split        <= 1'b0;
      r_size         <= SIZE_BYTE;
      r_beat         <= 2'd0;
      r_count        <= 3'd0;
      r_addr         <= '0;
      r_wdata        <= 32'h0;
      r_asm          <= 32'h0;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_err     <= 1'b0;
      r_resp_rdata   <= 32'h0;
      r_mem_a        <= '0;
      r_mem_wd       <= 32'h0;
      r_mem_size     <= SIZE_BYTE;
      r_mem_we       <= 1'b0;
      r_mem_unsigned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= i_req_we;
            r_unsigned  <= i_req_unsigned;
            r_size      <= i_req_size;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_split     <= w_mis;
            r_count     <= w_nbeats;
            r_beat      <= 2'd0;
            r_asm       <= 32'h0;
            r_req_ready <= 1'b0;
            if (w_illegal) begin
              // No memory traffic; answer with an error straight away
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else begin
              r_state  <= BEAT;
              r_mem_a  <= i_req_addr;
              r_mem_we <= i_req_we;
              if (w_mis) begin
                r_mem_size     <= SIZE_BYTE;
                r_mem_unsigned <= 1'b1;
                r_mem_wd       <= {24'h0, i_req_wdata[7:0]};
              end else begin
                r_mem_size     <= i_req_size;
                r_mem_unsigned <= i_req_unsigned;
                r_mem_wd       <= i_req_wdata;
              end
            end
          end
        end
        BEAT: begin
          if (!r_we) begin
            r_asm <= w_asm_next;
          end
          if (!w_last) begin
            r_beat   <= w_next_beat[1:0];
            r_mem_a  <= w_next_addr;
            r_mem_wd <= {24'h0, w_next_byte};
          end else begin
            r_state        <= RESP;
            r_mem_a        <= '0;
            r_mem_wd       <= 32'h0;
            r_mem_size     <= SIZE_BYTE;
            r_mem_we       <= 1'b0;
            r_mem_unsigned <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_resp_err     <= 1'b0;
            // Aligned loads are extended by the memory; split loads here
            if (r_we) begin
              r_resp_rdata <= 32'h0;
            end else if (r_split) begin
              r_resp_rdata <= w_ext;
            end else begin
              r_resp_rdata <= i_mem_rd;
            end
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_err     = r_resp_err;
  assign o_resp_rdata   = r_resp_rdata;
  assign o_mem_a        = r_mem_a;
  assign o_mem_wd       = r_mem_wd;
  assign o_mem_size     = r_mem_size;
  assign o_mem_we       = r_mem_we;
  assign o_mem_unsigned = r_mem_unsigned;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a byte memory
//               and a request-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  // Shared request fields; each DUT has its own valid
  logic        va = 1'b0, vb = 1'b0;
  logic        req_we = 1'b0, req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;

  logic        a_ready, a_rv, a_err, a_mwe, a_muns;
  logic [31:0] a_rdata, a_ma, a_mwd, a_mrd;
  logic [1:0]  a_msize;
  logic        b_ready, b_rv, b_err, b_mwe, b_muns;
  logic [31:0] b_rdata, b_ma, b_mwd;
  logic [1:0]  b_msize;

  load_store_unit #(.SPLIT_MISALIGNED(1), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(va), .o_req_ready(a_ready), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_size(req_size), .i_req_unsigned(req_uns),
    .o_resp_valid(a_rv), .o_resp_rdata(a_rdata), .o_resp_err(a_err),
    .o_mem_a(a_ma), .o_mem_wd(a_mwd), .o_mem_size(a_msize), .o_mem_we(a_mwe),
    .o_mem_unsigned(a_muns), .i_mem_rd(a_mrd));

  load_store_unit #(.SPLIT_MISALIGNED(0), .ADDR_WIDTH(32)) dut_ns (
    .clk(clk), .rst(rst),
    .i_req_valid(vb), .o_req_ready(b_ready), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_size(req_size), .i_req_unsigned(req_uns),
    .o_resp_valid(b_rv), .o_resp_rdata(b_rdata), .o_resp_err(b_err),
    .o_mem_a(b_ma), .o_mem_wd(b_mwd), .o_mem_size(b_msize), .o_mem_we(b_mwe),
    .o_mem_unsigned(b_muns), .i_mem_rd(32'h0));

  // Observation mux so one request task serves both instances
  logic        sel_b = 1'b0;
  logic        o_ready, o_rv, o_err, o_mwe, o_muns;
  logic [31:0] o_rdata, o_ma, o_mwd;
  logic [1:0]  o_msize;
  assign o_ready = sel_b ? b_ready : a_ready;
  assign o_rv    = sel_b ? b_rv    : a_rv;
  assign o_err   = sel_b ? b_err   : a_err;
  assign o_rdata = sel_b ? b_rdata : a_rdata;
  assign o_ma    = sel_b ? b_ma    : a_ma;
  assign o_mwd   = sel_b ? b_mwd   : a_mwd;
  assign o_msize = sel_b ? b_msize : a_msize;
  assign o_mwe   = sel_b ? b_mwe   : a_mwe;
  assign o_muns  = sel_b ? b_muns  : a_muns;

  // Byte-addressed memory (256 bytes, aliased on addr[7:0]) behind the main DUT
  logic [7:0] mem [256];
  logic [7:0] mb0, mb1, mb2, mb3;
  assign mb0 = mem[a_ma[7:0]];
  assign mb1 = mem[a_ma[7:0] + 8'd1];
  assign mb2 = mem[a_ma[7:0] + 8'd2];
  assign mb3 = mem[a_ma[7:0] + 8'd3];
  assign a_mrd = (a_msize == 2'b00) ? {{24{~a_muns & mb0[7]}}, mb0} :
                 (a_msize == 2'b01) ? {{16{~a_muns & mb1[7]}}, mb1, mb0} :
                                      {mb3, mb2, mb1, mb0};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (a_mwe) begin
      mem[a_ma[7:0]] <= a_mwd[7:0];
      if (a_msize != 2'b00) mem[a_ma[7:0] + 8'd1] <= a_mwd[15:8];
      if (a_msize == 2'b10) begin
        mem[a_ma[7:0] + 8'd2] <= a_mwd[23:16];
        mem[a_ma[7:0] + 8'd3] <= a_mwd[31:24];
      end
    end
  end

  // Reference model state: memory contents as the requests define them
  logic [7:0] rmem [256];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, check every beat, latency and response against the model
  task automatic do_req(input bit sb, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input logic uns, output logic [31:0] rd);
    logic        mis, ill, seen;
    int          nb, exp_lat, k;
    logic [31:0] exp_rd, mask, ai, tmp, ea, ewd;
    logic [1:0]  esz;
    logic        eu;
    mis = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
    ill = (size == 2'b11) || (mis && sb);
    nb  = 1 << size;
    exp_lat = ill ? 1 : (mis ? nb + 1 : 2);
    exp_rd  = 32'h0;
    if (!ill && !sb) begin
      for (int i = 0; i < nb; i++) begin
        ai  = addr + i;
        tmp = wdata >> (8 * i);
        if (we) rmem[ai[7:0]] = tmp[7:0];
        else    exp_rd = exp_rd | ({24'h0, rmem[ai[7:0]]} << (8 * i));
      end
      if (!we) begin
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        if (!uns && exp_rd[8 * nb - 1]) exp_rd = exp_rd | ~mask;
      end
    end
    sel_b = sb;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_uns = uns;
    if (sb) vb = 1'b1; else va = 1'b1;
    #1 chk("ready_before", o_ready, 1'b1);
    @(posedge clk);
    #1 va = 1'b0; vb = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (o_rv) seen = 1'b1;
      else begin
        ea  = mis ? addr + (k - 1) : addr;
        tmp = wdata >> (8 * (k - 1));
        ewd = mis ? {24'h0, tmp[7:0]} : wdata;
        esz = mis ? 2'b00 : size;
        eu  = mis ? 1'b1 : uns;
        chk("beat_we_addr", {o_mwe, o_ma}, {we, ea});
        chk("beat_data", {o_mwd, o_msize, o_muns}, {ewd, esz, eu});
      end
    end
    rd = o_rdata;
    chk("latency", k, exp_lat);
    chk("resp_err_data", {o_err, o_rdata}, {ill, exp_rd});
    chk("no_we_in_resp", o_mwe, 1'b0);
    @(negedge clk);
    chk("resp_one_cycle", {o_rv, o_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] rd;
    int bad, stray;
    for (int i = 0; i < 256; i++) rmem[i] = 8'h00;

    // Reset values
    #12;
    chk("rst_ready_valid", {a_ready, a_rv, a_err}, 3'b100);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_mem", {a_mwe, a_ma, a_mwd, a_msize, a_muns}, 68'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;

    // Aligned word store and reload
    do_req(0, 1'b1, 32'h0, 32'hDEAD_BEEF, 2'b10, 1'b0, rd);
    do_req(0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd);
    chk("ld_word_0", rd, 32'hDEAD_BEEF);

    // Misaligned word store and reload
    do_req(0, 1'b1, 32'h5, 32'h1122_3344, 2'b10, 1'b0, rd);
    do_req(0, 1'b0, 32'h5, 32'h0, 2'b10, 1'b0, rd);
    chk("ld_word_5", rd, 32'h1122_3344);

    // Misaligned half load across bytes 7/8
    do_req(0, 1'b1, 32'h7, 32'h01, 2'b00, 1'b0, rd);
    do_req(0, 1'b1, 32'h8, 32'h80, 2'b00, 1'b0, rd);
    do_req(0, 1'b0, 32'h7, 32'h0, 2'b01, 1'b0, rd);
    chk("ld_half7_s", rd, 32'hFFFF_8001);
    do_req(0, 1'b0, 32'h7, 32'h0, 2'b01, 1'b1, rd);
    chk("ld_half7_u", rd, 32'h0000_8001);

    // Aligned byte load, both extensions
    do_req(0, 1'b1, 32'h4, 32'hA5, 2'b00, 1'b0, rd);
    do_req(0, 1'b0, 32'h4, 32'h0, 2'b00, 1'b0, rd);
    chk("ld_byte4_s", rd, 32'hFFFF_FFA5);
    do_req(0, 1'b0, 32'h4, 32'h0, 2'b00, 1'b1, rd);
    chk("ld_byte4_u", rd, 32'h0000_00A5);

    // Illegal requests
    do_req(0, 1'b1, 32'h10, 32'h1234_5678, 2'b11, 1'b0, rd);
    do_req(1, 1'b0, 32'h2, 32'h0, 2'b10, 1'b0, rd);
    sel_b = 1'b0;

    // Reset during beat index 2 of a wrapping misaligned word store
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hCAFE_F00D;
    req_size = 2'b10; req_uns = 1'b0; va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_rst_beat2", {a_mwe, a_ma}, {1'b1, 32'h1});
    rst = 1'b1;
    #1;
    chk("rst_mid_mem", {a_mwe, a_ma, a_mwd}, 65'h0);
    chk("rst_mid_ctl", {a_ready, a_rv, a_err}, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_rv) stray++;
    end
    chk("no_resp_after_abort", stray, 0);
    chk("ready_after_rst", a_ready, 1'b1);
    chk("abort_bytes_written", {mem[8'hFF], mem[8'h00]}, 16'h0DF0);
    chk("abort_bytes_untouched", {mem[8'h01], mem[8'h02]}, 16'hBEAD);
    rmem[8'hFF] = 8'h0D;
    rmem[8'h00] = 8'hF0;

    // Uninterrupted rerun: beats at FFFFFFFF, 0, 1, 2
    do_req(0, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D, 2'b10, 1'b0, rd);
    chk("wrap_bytes", {mem[8'hFF], mem[8'h00], mem[8'h01], mem[8'h02]}, 32'h0DF0_FECA);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req(0, 1'($urandom_range(0, 1)), 32'h20 + 32'($urandom_range(0, 95)),
             $urandom, sz, 1'($urandom_range(0, 1)), rd);
    end

    // Whole-memory agreement with the model
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== rmem[i]) bad++;
    chk("memory_image", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
